// File: rtl/pipeline_hazard_ctrl_if.sv
// Control bundle between the decode/fetch side (master) and the hazard sequencer (slave).
interface pipeline_hazard_ctrl_if #(
   parameter int CNT_W = 16
);
   logic [4:0]       id_rs;
   logic [4:0]       id_rt;
   logic             id_use_rs;
   logic             id_use_rt;
   logic [4:0]       ex_rd;
   logic             ex_wr;
   logic [4:0]       mem_rd;
   logic             mem_wr;
   logic [4:0]       wb_rd;
   logic             wb_wr;
   logic             redirect;
   logic [8:0]       pc_idx;
   logic             pc_en;
   logic             ifid_en;
   logic             ifid_flush;
   logic             idex_bubble;
   logic             exmem_flush;
   logic             halted;
   logic [CNT_W-1:0] stall_cnt;
   logic [CNT_W-1:0] flush_cnt;

   modport master (
      output id_rs, id_rt, id_use_rs, id_use_rt,
      output ex_rd, ex_wr, mem_rd, mem_wr, wb_rd, wb_wr,
      output redirect, pc_idx,
      input  pc_en, ifid_en, ifid_flush, idex_bubble, exmem_flush, halted,
      input  stall_cnt, flush_cnt
   );

   modport slave (
      input  id_rs, id_rt, id_use_rs, id_use_rt,
      input  ex_rd, ex_wr, mem_rd, mem_wr, wb_rd, wb_wr,
      input  redirect, pc_idx,
      output pc_en, ifid_en, ifid_flush, idex_bubble, exmem_flush, halted,
      output stall_cnt, flush_cnt
   );
endinterface

// File: rtl/pipeline_hazard_ctrl.sv
// Pipeline sequencer for the 5-stage MIPS core: RAW stalls, taken-branch squash,
// end-of-program drain/halt, and saturating stall/flush event counters.
module pipeline_hazard_ctrl #(
   parameter int LAST_IDX  = 127,
   parameter int DRAIN_CYC = 4,
   parameter int WB_FWD    = 1,
   parameter int CNT_W     = 16
) (
   input logic                   clk,
   input logic                   rst,
   pipeline_hazard_ctrl_if.slave bus
);
   localparam int            DW         = (DRAIN_CYC > 1) ? $clog2(DRAIN_CYC) : 1;
   localparam logic [DW-1:0] DRAIN_LAST = DW'(DRAIN_CYC - 1);

   typedef enum logic [1:0] {RUN, STALL, DRAIN, HALT} state_t;

   state_t           state;
   logic [DW-1:0]    drain_cnt;
   logic [CNT_W-1:0] stall_cnt;
   logic [CNT_W-1:0] flush_cnt;
   logic             rs_hit;
   logic             rt_hit;
   logic             raw;
   logic             past_end;

   // Register $0 is hardwired, so it never creates a dependency; a WB writer is
   // only a hazard when the regfile cannot write-before-read.
   always_comb begin
      rs_hit = (bus.id_rs != 5'd0) &&
               ((bus.ex_wr  && (bus.ex_rd  == bus.id_rs)) ||
                (bus.mem_wr && (bus.mem_rd == bus.id_rs)) ||
                ((WB_FWD == 0) && bus.wb_wr && (bus.wb_rd == bus.id_rs)));
      rt_hit = (bus.id_rt != 5'd0) &&
               ((bus.ex_wr  && (bus.ex_rd  == bus.id_rt)) ||
                (bus.mem_wr && (bus.mem_rd == bus.id_rt)) ||
                ((WB_FWD == 0) && bus.wb_wr && (bus.wb_rd == bus.id_rt)));
      raw      = (bus.id_use_rs && rs_hit) || (bus.id_use_rt && rt_hit);
      past_end = (bus.pc_idx >= 9'(LAST_IDX));
   end

   // Redirect outranks a hazard, which outranks the drain/halt behaviour.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state     <= RUN;
         drain_cnt <= '0;
         stall_cnt <= '0;
         flush_cnt <= '0;
      end else if (bus.redirect) begin
         state     <= RUN;
         drain_cnt <= '0;
         if (flush_cnt != '1)
            flush_cnt <= flush_cnt + CNT_W'(1);
      end else if (raw) begin
         if (stall_cnt != '1)
            stall_cnt <= stall_cnt + CNT_W'(1);
         if (state == RUN)
            state <= STALL;
      end else begin
         unique case (state)
            RUN: begin
               if (past_end) begin
                  state     <= DRAIN;
                  drain_cnt <= '0;
               end
            end
            STALL: state <= RUN;
            DRAIN: begin
               if (drain_cnt == DRAIN_LAST)
                  state <= HALT;
               else
                  drain_cnt <= drain_cnt + DW'(1);
            end
            HALT:    state <= HALT;
            default: state <= RUN;
         endcase
      end
   end

   // Control outputs follow state and inputs directly and are forced low in reset.
   always_comb begin
      bus.pc_en       = 1'b1;
      bus.ifid_en     = 1'b1;
      bus.ifid_flush  = 1'b0;
      bus.idex_bubble = 1'b0;
      bus.exmem_flush = 1'b0;
      bus.halted      = 1'b0;
      if (rst) begin
         bus.pc_en   = 1'b0;
         bus.ifid_en = 1'b0;
      end else if (bus.redirect) begin
         bus.ifid_flush  = 1'b1;
         bus.idex_bubble = 1'b1;
         bus.exmem_flush = 1'b1;
      end else begin
         unique case (state)
            RUN: begin
               if (past_end)
                  bus.pc_en = 1'b0;
            end
            DRAIN: begin
               bus.pc_en      = 1'b0;
               bus.ifid_flush = 1'b1;
            end
            HALT: begin
               bus.pc_en   = 1'b0;
               bus.ifid_en = 1'b0;
               bus.halted  = 1'b1;
            end
            default: ;
         endcase
         if (raw) begin
            bus.pc_en       = 1'b0;
            bus.ifid_en     = 1'b0;
            bus.ifid_flush  = 1'b0;
            bus.idex_bubble = 1'b1;
         end
      end
   end

   assign bus.stall_cnt = stall_cnt;
   assign bus.flush_cnt = flush_cnt;

endmodule
